// File: rtl/z80fi_retire_collector.sv
// rtl/z80fi_retire_collector.sv - assembles per-cycle core events into one retired-instruction record
//
// Optional feature macro: Z80FI_ORDER_EN (adds the 64-bit z80fi_order retirement index output).
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   cpu_insn_start, cpu_pc          new instruction begins; its PC
//   cpu_fetch_valid, cpu_fetch_data instruction byte fetched
//   cpu_reg{1,2}_rd/_rnum/_rdata    register read port events
//   cpu_mem_wr/_waddr/_wdata        memory write event
//   cpu_retire, cpu_pc_next         instruction completes; PC after it
//   z80fi_*                         retired-instruction record, qualified by one-cycle z80fi_valid
module z80fi_retire_collector #(
    parameter int MAX_INSN_LEN = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cpu_insn_start,
    input  logic [15:0]               cpu_pc,
    input  logic                      cpu_fetch_valid,
    input  logic [7:0]                cpu_fetch_data,
    input  logic                      cpu_reg1_rd,
    input  logic [3:0]                cpu_reg1_rnum,
    input  logic [15:0]               cpu_reg1_rdata,
    input  logic                      cpu_reg2_rd,
    input  logic [3:0]                cpu_reg2_rnum,
    input  logic [15:0]               cpu_reg2_rdata,
    input  logic                      cpu_mem_wr,
    input  logic [15:0]               cpu_mem_waddr,
    input  logic [7:0]                cpu_mem_wdata,
    input  logic                      cpu_retire,
    input  logic [15:0]               cpu_pc_next,
    output logic                      z80fi_valid,
    output logic [8*MAX_INSN_LEN-1:0] z80fi_insn,
    output logic [2:0]                z80fi_insn_len,
    output logic [15:0]               z80fi_pc_rdata,
    output logic [15:0]               z80fi_pc_wdata,
    output logic                      z80fi_reg1_rd,
    output logic [3:0]                z80fi_reg1_rnum,
    output logic [15:0]               z80fi_reg1_rdata,
    output logic                      z80fi_reg2_rd,
    output logic [3:0]                z80fi_reg2_rnum,
    output logic [15:0]               z80fi_reg2_rdata,
    output logic                      z80fi_mem_wr,
    output logic [15:0]               z80fi_mem_waddr,
    output logic [7:0]                z80fi_mem_wdata,
`ifdef Z80FI_ORDER_EN
    output logic [63:0]               z80fi_order,
`endif
    output logic                      z80fi_error
);

    localparam int IW = 8 * MAX_INSN_LEN;

    typedef enum logic {IDLE, COLLECT} state_t;

    typedef struct packed {
        logic [IW-1:0] insn;
        logic [2:0]    len;
        logic [15:0]   pc;
        logic          r1_rd;
        logic [3:0]    r1_num;
        logic [15:0]   r1_data;
        logic          r2_rd;
        logic [3:0]    r2_num;
        logic [15:0]   r2_data;
        logic          mw;
        logic [15:0]   waddr;
        logic [7:0]    wdata;
        logic          err;
    } rec_t;

    state_t state, state_next;
    rec_t   acc, nx;
    logic   retire_now, start_new, track;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // nx is the accumulator as it stands after this cycle's events, so a
    // retiring record already includes the retire-cycle events.
    always_comb begin
        state_next = state;
        nx         = acc;
        retire_now = (state == COLLECT) && cpu_retire;
        // Start alongside a retire opens a fresh record after the old one is
        // emitted; otherwise the start rebases the accumulator right here.
        start_new  = cpu_insn_start && !retire_now;
        track      = start_new || (state == COLLECT);

        if (start_new) begin
            nx     = '0;
            nx.pc  = cpu_pc;
            nx.err = (state == COLLECT);   // abandoned instruction
        end

        if (track) begin
            if (cpu_fetch_valid) begin
                if (nx.len < 3'(MAX_INSN_LEN)) begin
                    for (int k = 0; k < MAX_INSN_LEN; k++)
                        if (nx.len == 3'(k)) nx.insn[8*k +: 8] = cpu_fetch_data;
                    nx.len = nx.len + 3'd1;
                end else begin
                    nx.err = 1'b1;
                end
            end
            if (cpu_reg1_rd) begin
                if (nx.r1_rd) nx.err = 1'b1;
                nx.r1_rd   = 1'b1;
                nx.r1_num  = cpu_reg1_rnum;
                nx.r1_data = cpu_reg1_rdata;
            end
            if (cpu_reg2_rd) begin
                if (nx.r2_rd) nx.err = 1'b1;
                nx.r2_rd   = 1'b1;
                nx.r2_num  = cpu_reg2_rnum;
                nx.r2_data = cpu_reg2_rdata;
            end
            if (cpu_mem_wr) begin
                if (nx.mw) nx.err = 1'b1;
                nx.mw    = 1'b1;
                nx.waddr = cpu_mem_waddr;
                nx.wdata = cpu_mem_wdata;
            end
        end

        if (retire_now)     state_next = cpu_insn_start ? COLLECT : IDLE;
        else if (start_new) state_next = COLLECT;
    end

`ifdef Z80FI_ORDER_EN
    logic [63:0] order_cnt;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            acc              <= '0;
            z80fi_valid      <= 1'b0;
            z80fi_insn       <= '0;
            z80fi_insn_len   <= '0;
            z80fi_pc_rdata   <= '0;
            z80fi_pc_wdata   <= '0;
            z80fi_reg1_rd    <= 1'b0;
            z80fi_reg1_rnum  <= '0;
            z80fi_reg1_rdata <= '0;
            z80fi_reg2_rd    <= 1'b0;
            z80fi_reg2_rnum  <= '0;
            z80fi_reg2_rdata <= '0;
            z80fi_mem_wr     <= 1'b0;
            z80fi_mem_waddr  <= '0;
            z80fi_mem_wdata  <= '0;
            z80fi_error      <= 1'b0;
`ifdef Z80FI_ORDER_EN
            z80fi_order      <= '0;
            order_cnt        <= '0;
`endif
        end else begin
            z80fi_valid <= retire_now;
            if (retire_now) begin
                z80fi_insn       <= nx.insn;
                z80fi_insn_len   <= nx.len;
                z80fi_pc_rdata   <= nx.pc;
                z80fi_pc_wdata   <= cpu_pc_next;
                z80fi_reg1_rd    <= nx.r1_rd;
                z80fi_reg1_rnum  <= nx.r1_num;
                z80fi_reg1_rdata <= nx.r1_data;
                z80fi_reg2_rd    <= nx.r2_rd;
                z80fi_reg2_rnum  <= nx.r2_num;
                z80fi_reg2_rdata <= nx.r2_data;
                z80fi_mem_wr     <= nx.mw;
                z80fi_mem_waddr  <= nx.waddr;
                z80fi_mem_wdata  <= nx.wdata;
                z80fi_error      <= nx.err | (nx.len == 3'd0);
`ifdef Z80FI_ORDER_EN
                z80fi_order      <= order_cnt;
                order_cnt        <= order_cnt + 64'd1;
`endif
            end
            if (retire_now && cpu_insn_start) begin
                acc    <= '0;
                acc.pc <= cpu_pc;
            end else if (track) begin
                acc <= nx;
            end
        end
    end

endmodule

// File: tb/tb_z80fi_retire_collector.sv
// tb/tb_z80fi_retire_collector.sv - scoreboard bench for z80fi_retire_collector
module tb_z80fi_retire_collector;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_insn_start;
    logic [15:0] cpu_pc;
    logic        cpu_fetch_valid;
    logic [7:0]  cpu_fetch_data;
    logic        cpu_reg1_rd, cpu_reg2_rd;
    logic [3:0]  cpu_reg1_rnum, cpu_reg2_rnum;
    logic [15:0] cpu_reg1_rdata, cpu_reg2_rdata;
    logic        cpu_mem_wr;
    logic [15:0] cpu_mem_waddr;
    logic [7:0]  cpu_mem_wdata;
    logic        cpu_retire;
    logic [15:0] cpu_pc_next;

    logic        z80fi_valid;
    logic [31:0] z80fi_insn;
    logic [2:0]  z80fi_insn_len;
    logic [15:0] z80fi_pc_rdata, z80fi_pc_wdata;
    logic        z80fi_reg1_rd, z80fi_reg2_rd;
    logic [3:0]  z80fi_reg1_rnum, z80fi_reg2_rnum;
    logic [15:0] z80fi_reg1_rdata, z80fi_reg2_rdata;
    logic        z80fi_mem_wr;
    logic [15:0] z80fi_mem_waddr;
    logic [7:0]  z80fi_mem_wdata;
    logic        z80fi_error;
`ifdef Z80FI_ORDER_EN
    logic [63:0] z80fi_order;
`endif

    z80fi_retire_collector #(.MAX_INSN_LEN(MAX)) dut (
        .clk(clk), .reset(reset),
        .cpu_insn_start(cpu_insn_start), .cpu_pc(cpu_pc),
        .cpu_fetch_valid(cpu_fetch_valid), .cpu_fetch_data(cpu_fetch_data),
        .cpu_reg1_rd(cpu_reg1_rd), .cpu_reg1_rnum(cpu_reg1_rnum), .cpu_reg1_rdata(cpu_reg1_rdata),
        .cpu_reg2_rd(cpu_reg2_rd), .cpu_reg2_rnum(cpu_reg2_rnum), .cpu_reg2_rdata(cpu_reg2_rdata),
        .cpu_mem_wr(cpu_mem_wr), .cpu_mem_waddr(cpu_mem_waddr), .cpu_mem_wdata(cpu_mem_wdata),
        .cpu_retire(cpu_retire), .cpu_pc_next(cpu_pc_next),
        .z80fi_valid(z80fi_valid), .z80fi_insn(z80fi_insn), .z80fi_insn_len(z80fi_insn_len),
        .z80fi_pc_rdata(z80fi_pc_rdata), .z80fi_pc_wdata(z80fi_pc_wdata),
        .z80fi_reg1_rd(z80fi_reg1_rd), .z80fi_reg1_rnum(z80fi_reg1_rnum), .z80fi_reg1_rdata(z80fi_reg1_rdata),
        .z80fi_reg2_rd(z80fi_reg2_rd), .z80fi_reg2_rnum(z80fi_reg2_rnum), .z80fi_reg2_rdata(z80fi_reg2_rdata),
        .z80fi_mem_wr(z80fi_mem_wr), .z80fi_mem_waddr(z80fi_mem_waddr), .z80fi_mem_wdata(z80fi_mem_wdata),
`ifdef Z80FI_ORDER_EN
        .z80fi_order(z80fi_order),
`endif
        .z80fi_error(z80fi_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0]     insn;
        int              len;
        logic [15:0]     pc_r, pc_w;
        logic            r1rd;
        logic [3:0]      r1n;
        logic [15:0]     r1d;
        logic            r2rd;
        logic [3:0]      r2n;
        logic [15:0]     r2d;
        logic            mw;
        logic [15:0]     wa;
        logic [7:0]      wd;
        logic            err;
        int              cyc;
        longint unsigned ord;
    } rec_t;

    rec_t            exp_q[$];
    rec_t            m;
    bit              m_busy;
    longint unsigned m_ord;
    int              cyc = 0;
    int              vectors = 0;
    int              miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic rec_t blank();
        rec_t r;
        r.insn = '0; r.len = 0; r.pc_r = '0; r.pc_w = '0;
        r.r1rd = 0; r.r1n = '0; r.r1d = '0;
        r.r2rd = 0; r.r2n = '0; r.r2d = '0;
        r.mw = 0; r.wa = '0; r.wd = '0; r.err = 0; r.cyc = 0; r.ord = 0;
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: consumes one cycle's inputs as a retirement-level event list.
    task automatic model_cycle();
        bit closing, opening;
        rec_t r;
        if (reset) begin
            m_busy = 0; m = blank(); m_ord = 0;
            return;
        end
        closing = m_busy && cpu_retire;
        opening = cpu_insn_start && !closing;
        if (opening) begin
            r = blank();
            r.pc_r = cpu_pc;
            r.err = m_busy;
            m = r;
            m_busy = 1;
        end
        if (m_busy) begin
            if (cpu_fetch_valid) begin
                if (m.len < MAX) begin
                    m.insn = m.insn | (32'(cpu_fetch_data) << (8 * m.len));
                    m.len++;
                end else m.err = 1;
            end
            if (cpu_reg1_rd) begin
                if (m.r1rd) m.err = 1;
                m.r1rd = 1; m.r1n = cpu_reg1_rnum; m.r1d = cpu_reg1_rdata;
            end
            if (cpu_reg2_rd) begin
                if (m.r2rd) m.err = 1;
                m.r2rd = 1; m.r2n = cpu_reg2_rnum; m.r2d = cpu_reg2_rdata;
            end
            if (cpu_mem_wr) begin
                if (m.mw) m.err = 1;
                m.mw = 1; m.wa = cpu_mem_waddr; m.wd = cpu_mem_wdata;
            end
        end
        if (closing) begin
            r = m;
            r.pc_w = cpu_pc_next;
            if (r.len == 0) r.err = 1;
            r.cyc = cyc + 1;
            r.ord = m_ord;
            m_ord++;
            exp_q.push_back(r);
            if (cpu_insn_start) begin
                m = blank();
                m.pc_r = cpu_pc;
            end else m_busy = 0;
        end
    endtask

    task automatic idle_inputs();
        reset = 0; cpu_insn_start = 0; cpu_pc = '0;
        cpu_fetch_valid = 0; cpu_fetch_data = '0;
        cpu_reg1_rd = 0; cpu_reg1_rnum = '0; cpu_reg1_rdata = '0;
        cpu_reg2_rd = 0; cpu_reg2_rnum = '0; cpu_reg2_rdata = '0;
        cpu_mem_wr = 0; cpu_mem_waddr = '0; cpu_mem_wdata = '0;
        cpu_retire = 0; cpu_pc_next = '0;
    endtask

    task automatic tick();
        model_cycle();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic fetch(input logic [7:0] b);
        cpu_fetch_valid = 1; cpu_fetch_data = b;
    endtask

    // Monitor: every pulse must match the oldest expected record, in the expected cycle.
    always @(negedge clk) begin
        if (z80fi_valid) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL spurious_pulse: got valid=1 expected no record at cycle %0d", cyc);
            end else begin
                rec_t e;
                logic [134:0] act, exv;
                e = exp_q.pop_front();
                act = {z80fi_insn, z80fi_insn_len, z80fi_pc_rdata, z80fi_pc_wdata,
                       z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata,
                       z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata,
                       z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata, z80fi_error};
                exv = {e.insn, 3'(e.len), e.pc_r, e.pc_w, e.r1rd, e.r1n, e.r1d,
                       e.r2rd, e.r2n, e.r2d, e.mw, e.wa, e.wd, e.err};
                if (act !== exv || cyc != e.cyc) begin
                    miscompares++;
                    $display("FAIL record: got %h @cyc %0d expected %h @cyc %0d", act, cyc, exv, e.cyc);
                end
`ifdef Z80FI_ORDER_EN
                vectors++;
                if (z80fi_order !== e.ord) begin
                    miscompares++;
                    $display("FAIL order: got %0d expected %0d", z80fi_order, e.ord);
                end
`endif
            end
        end
    end

    initial begin
        m = blank(); m_busy = 0; m_ord = 0;
        idle_inputs();
        reset = 1; tick();
        reset = 1; tick();
        chk("reset_valid", 64'(z80fi_valid), 0);
        chk("reset_insn", 64'(z80fi_insn), 0);
        chk("reset_len", 64'(z80fi_insn_len), 0);
        chk("reset_pc", 64'({z80fi_pc_rdata, z80fi_pc_wdata}), 0);
        chk("reset_err", 64'(z80fi_error), 0);

        // LD (HL),B
        cpu_insn_start = 1; cpu_pc = 16'h1000; fetch(8'h70); tick();
        cpu_reg1_rd = 1; cpu_reg1_rnum = 4'h6; cpu_reg1_rdata = 16'h4000;
        cpu_reg2_rd = 1; cpu_reg2_rnum = 4'h0; cpu_reg2_rdata = 16'h00A5; tick();
        cpu_mem_wr = 1; cpu_mem_waddr = 16'h4000; cpu_mem_wdata = 8'hA5;
        cpu_retire = 1; cpu_pc_next = 16'h1001;
        cpu_insn_start = 1; cpu_pc = 16'h1001; tick();
        chk("ld_valid", 64'(z80fi_valid), 1);
        chk("ld_insn", 64'(z80fi_insn[7:0]), 64'h70);
        chk("ld_len", 64'(z80fi_insn_len), 1);
        chk("ld_mem", 64'({z80fi_mem_waddr, z80fi_mem_wdata}), 64'h4000A5);
        chk("ld_err", 64'(z80fi_error), 0);
        chk("ld_pcw", 64'(z80fi_pc_wdata), 64'h1001);

        // back-to-back second record
        fetch(8'h3E); tick();
        chk("pulse_width", 64'(z80fi_valid), 0);
        fetch(8'h12); cpu_retire = 1; cpu_pc_next = 16'h1003; tick();
        chk("b2b_len", 64'(z80fi_insn_len), 2);
        chk("b2b_insn", 64'(z80fi_insn[15:0]), 64'h123E);
        chk("b2b_pcr", 64'(z80fi_pc_rdata), 64'h1001);
        chk("b2b_flags", 64'({z80fi_reg1_rd, z80fi_mem_wr, z80fi_error}), 0);

        // overflow
        cpu_insn_start = 1; cpu_pc = 16'h2000; fetch(8'hDD); tick();
        fetch(8'h36); tick();
        fetch(8'h05); tick();
        fetch(8'h7F); tick();
        fetch(8'h99); tick();
        cpu_retire = 1; cpu_pc_next = 16'h2004; tick();
        chk("ovf_len", 64'(z80fi_insn_len), 4);
        chk("ovf_insn", 64'(z80fi_insn), 64'h7F0536DD);
        chk("ovf_err", 64'(z80fi_error), 1);

        // double memory write
        cpu_insn_start = 1; cpu_pc = 16'h3000; fetch(8'h77); tick();
        cpu_mem_wr = 1; cpu_mem_waddr = 16'h2000; cpu_mem_wdata = 8'h11; tick();
        cpu_mem_wr = 1; cpu_mem_waddr = 16'h2001; cpu_mem_wdata = 8'h22;
        cpu_retire = 1; cpu_pc_next = 16'h3001; tick();
        chk("dw_mem", 64'({z80fi_mem_waddr, z80fi_mem_wdata}), 64'h200122);
        chk("dw_err", 64'(z80fi_error), 1);

        // reset mid-collection, then retire while idle
        cpu_insn_start = 1; cpu_pc = 16'h5000; fetch(8'h01); tick();
        fetch(8'h02); tick();
        reset = 1; tick();
        cpu_retire = 1; cpu_pc_next = 16'h5002; tick();
        chk("rst_valid", 64'(z80fi_valid), 0);
        chk("rst_fields", 64'({z80fi_insn, z80fi_insn_len, z80fi_error}), 0);
        cpu_retire = 1; tick();
        chk("idle_retire", 64'(z80fi_valid), 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 1) begin
                reset = 1;
            end else begin
                cpu_insn_start  = m_busy ? ($urandom_range(0, 99) < 12) : ($urandom_range(0, 99) < 35);
                cpu_pc          = 16'($urandom);
                cpu_fetch_valid = $urandom_range(0, 99) < 50;
                cpu_fetch_data  = 8'($urandom);
                cpu_reg1_rd     = $urandom_range(0, 99) < 20;
                cpu_reg1_rnum   = 4'($urandom);
                cpu_reg1_rdata  = 16'($urandom);
                cpu_reg2_rd     = $urandom_range(0, 99) < 20;
                cpu_reg2_rnum   = 4'($urandom);
                cpu_reg2_rdata  = 16'($urandom);
                cpu_mem_wr      = $urandom_range(0, 99) < 12;
                cpu_mem_waddr   = 16'($urandom);
                cpu_mem_wdata   = 8'($urandom);
                cpu_retire      = m_busy ? ($urandom_range(0, 99) < 25)
                                         : (!cpu_insn_start && $urandom_range(0, 99) < 15);
                cpu_pc_next     = 16'($urandom);
            end
            tick();
        end
        repeat (3) tick();
        chk("queue_drained", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/z80fi_retire_collector.md
Name: z80fi_retire_collector

Overview:
- Upstream stage of every z80fi_insn_spec_* checker.
- Observes the core's per-cycle execution events (fetch bytes, register reads, memory write, PC) and assembles them into one retired-instruction record.
- Emits the record on the z80fi_* bus with a single-cycle z80fi_valid pulse.
- Instruction-spec modules compare their spec_* outputs against this record.

Parameters:
MAX_INSN_LEN, 4, maximum instruction bytes captured (1..4); z80fi_insn is 8*MAX_INSN_LEN bits wide.

Ports:
clk  in  1  system clock; one clock domain.
reset  in  1  synchronous, active-high reset.
cpu_insn_start  in  1  first cycle of a new instruction; cpu_pc valid this cycle.
cpu_pc  in  16  PC of the instruction starting (sampled on cpu_insn_start).
cpu_fetch_valid  in  1  instruction byte fetched for the current instruction.
cpu_fetch_data  in  8  fetched byte.
cpu_reg1_rd / cpu_reg2_rd  in  1 each  register-port read strobes.
cpu_reg1_rnum / cpu_reg2_rnum  in  4 each  register numbers (REG_* encoding).
cpu_reg1_rdata / cpu_reg2_rdata  in  16 each  read data.
cpu_mem_wr  in  1  memory write strobe.
cpu_mem_waddr  in  16  write address.
cpu_mem_wdata  in  8  write data.
cpu_retire  in  1  current instruction completes this cycle.
cpu_pc_next  in  16  PC after the instruction (sampled on cpu_retire).
z80fi_valid  out  1  one-cycle pulse: record valid.
z80fi_insn  out  8*MAX_INSN_LEN  bytes in fetch order; byte k at [8k+7:8k].
z80fi_insn_len  out  3  bytes captured.
z80fi_pc_rdata / z80fi_pc_wdata  out  16 each  PC at start / after.
z80fi_reg1_rd, z80fi_reg1_rnum, z80fi_reg1_rdata  out  1/4/16  first read port record.
z80fi_reg2_rd, z80fi_reg2_rnum, z80fi_reg2_rdata  out  1/4/16  second read port record.
z80fi_mem_wr, z80fi_mem_waddr, z80fi_mem_wdata  out  1/16/8  memory write record.
z80fi_error  out  1  record is malformed (see below); valid only with z80fi_valid.

Behaviour:
- Reset: all outputs 0; state IDLE; accumulators cleared.
- States:
  - IDLE: ignores every event except cpu_insn_start.
  - COLLECT.
- IDLE -> COLLECT on cpu_insn_start:
  - clears accumulators; latches cpu_pc.
  - same-cycle fetch/read/write events count toward the new instruction.
- COLLECT:
  - Each cpu_fetch_valid stores the byte at index len, then len++.
  - At len == MAX_INSN_LEN, a further fetch sets the overflow error; byte dropped; len saturates.
  - regN_rd latches rnum/rdata and sets the record flag.
  - A second read on the same port within one instruction overwrites the data and sets error.
  - cpu_mem_wr latches waddr/wdata; a second write sets error.
- cpu_retire in COLLECT:
  - the next cycle outputs the record with z80fi_valid=1.
  - pc_wdata = cpu_pc_next; events on the retire cycle itself are included.
  - Output fields hold until the next retire; z80fi_valid lasts exactly 1 cycle.
- cpu_retire with cpu_insn_start in the same cycle: the current record retires with that cycle's events; a new collection starts with cleared accumulators and the new PC. Remains in COLLECT.
- cpu_retire without cpu_insn_start: -> IDLE.
- cpu_retire in IDLE: ignored; no pulse.
- cpu_insn_start in COLLECT without retire: the unretired instruction is discarded, restart, and error is set on the next emitted record (abandoned instruction).
- Retire with len==0 sets error.
- Reset mid-COLLECT: the record is discarded, no pulse, IDLE next cycle.
- Latency: retire cycle N -> z80fi_valid at N+1.

Optional Feature:
Z80FI_ORDER_EN
- Defined: adds output z80fi_order (64 bits).
  - Reset 0; increments by 1 after each emitted record.
  - Carries the retirement index of the current record (first record = 0).
  - Wraps modulo 2^64.
- Undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- LD (HL),B: start pc=0x1000, fetch 0x70, reg1 HL=0x4000, reg2 B=0x00A5, mem_wr 0x4000/0xA5, retire pc_next=0x1001 -> next cycle valid=1, insn[7:0]=0x70, len=1, mem_waddr=0x4000, mem_wdata=0xA5, error=0.
- Back-to-back: retire+start same cycle with pc=0x1001, then fetch 0x3E,0x12, retire -> second record len=2, insn[15:0]=0x123E, pc_rdata=0x1001, reg1_rd=0, mem_wr=0.
- Overflow with MAX_INSN_LEN=4: five fetches 0xDD,0x36,0x05,0x7F,0x99 -> len=4, insn=0x7F0536DD, error=1.
- Double memory write (0x2000/0x11 then 0x2001/0x22) -> record holds 0x2001/0x22, error=1.
- Reset asserted after two fetches, then retire -> no valid pulse, all outputs 0; cpu_retire while IDLE -> no pulse.
- With Z80FI_ORDER_EN: three retirements -> z80fi_order = 0,1,2 on successive pulses; after reset the next record has order 0.
